// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the 32-bit ALU.
// Accepts one load/store from EX, issues it to data memory over a valid/ready
// port and, for loads, aligns and extends the response before handing it to
// writeback. Misaligned or illegal ops never reach memory and raise a pulse.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         EX handshake (req_ready low = pipeline stall)
//   req_store, req_funct3       op kind and RISC-V width code
//   req_addr, req_wdata, req_rd effective address, store data, load dest tag
//   mem_req_valid/mem_req_ready memory request handshake
//   mem_addr, mem_we, mem_wdata word address, byte write mask, lane data
//   mem_resp_valid/_data        load response (always accepted in WAIT_RESP)
//   wb_valid, wb_rd, wb_data    load result, one-cycle pulse
//   misaligned                  one-cycle pulse for a misaligned/illegal op
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a new op
// REQ       | memory request presented, waiting for mem_req_ready
// WAIT_RESP | load issued, waiting for mem_resp_valid
// ERR       | misaligned/illegal op, misaligned pulsed for one cycle
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RESP, S_ERR} state_t;

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  logic        req_bad;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Legality and alignment are judged on the incoming op so the error path
  // is decided at accept time and memory is never touched.
  always_comb begin
    req_bad = 1'b0;
    if (req_store) begin
      case (req_funct3)
        3'b000:  req_bad = 1'b0;
        3'b001:  req_bad = req_addr[0];
        3'b010:  req_bad = |req_addr[1:0];
        default: req_bad = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: req_bad = 1'b0;
        3'b001, 3'b101: req_bad = req_addr[0];
        3'b010:         req_bad = |req_addr[1:0];
        default:        req_bad = 1'b1;
      endcase
    end
  end

  assign off = addr_q[1:0];

  always_comb begin
    mem_we    = 4'b0000;
    mem_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00:   mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
    if (state_q == S_REQ && store_q) begin
      case (funct3_q[1:0])
        2'b00:   mem_we = 4'b0001 << off;
        2'b01:   mem_we = 4'b0011 << off;
        default: mem_we = 4'b1111;
      endcase
    end
  end

  assign shifted = mem_resp_data >> {off, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'h000000, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = mem_resp_data;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          state_d  = req_bad ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = store_q ? S_IDLE : S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (mem_resp_valid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = load_val;
          wb_rd_d    = rd_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      store_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rd_q       <= 5'h0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'h0;
      wb_rd_q    <= 5'h0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign misaligned    = (state_q == S_ERR);
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the 32-bit ALU: takes the ALU result as the effective address, plus the store operand and RISC-V funct3 width code. Issues one request to a data memory over a valid/ready port and, for loads, waits for the response, aligns it, sign- or zero-extends it and hands the value to writeback with its destination register tag. Misaligned or illegal accesses never reach memory and are flagged instead. One access is in flight at a time; `req_ready` low is the pipeline stall.

## Interface
- No parameters; all data and address paths are 32 bits.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: EX presents a memory operation.
- `req_ready` out 1: high only in IDLE while `rst` is low; an op is accepted on `req_valid & req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in 32: effective address from the ALU output.
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination register tag.
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_we` out 4: byte write mask; 0000 for loads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_resp_valid` in 1, `mem_resp_data` in 32: load response; no ready, always accepted in WAIT_RESP.
- `wb_valid` out 1, `wb_rd` out 5, `wb_data` out 32: load result, one-cycle pulse.
- `misaligned` out 1: one-cycle pulse for a misaligned or illegal op.

## Operation
- Accept registers op, addr, wdata, funct3 and rd; all are held stable until the op retires.
- Illegal ops are loads with funct3 011/110/111 and stores with funct3 other than 000/001/010.
- Misaligned ops are H/HU with `addr[0]=1`, and W with `addr[1:0]!=0`.
- An illegal or misaligned op goes IDLE -> ERR. ERR asserts `misaligned` for 1 cycle, then returns to IDLE with no memory request and no writeback.
- A legal op goes IDLE -> REQ.
  - REQ drives `mem_req_valid=1` until `mem_req_ready`. `mem_addr`, `mem_we` and `mem_wdata` are stable while waiting.
  - On handshake, a store goes to IDLE (retired) and a load goes to WAIT_RESP.
- WAIT_RESP: on `mem_resp_valid`, capture aligned data and go to IDLE. `wb_valid` pulses in the following cycle.
- Store lanes, with `off = addr[1:0]`:
  - SB: `mem_wdata = {4{wdata[7:0]}}`, `mem_we = 0001 << off`.
  - SH: `mem_wdata = {2{wdata[15:0]}}`, `mem_we = 0011 << off`.
  - SW: `mem_wdata = wdata`, `mem_we = 1111`.
- Load extract: `x = resp_data >> (8*off)`.
  - B: sign-extend `x[7:0]`. BU: zero-extend `x[7:0]`.
  - H: sign-extend `x[15:0]`. HU: zero-extend `x[15:0]`.
  - W: `resp_data` unchanged.
- `mem_resp_valid` outside WAIT_RESP is ignored.

## Timing
- Reset values: state IDLE; `mem_req_valid`, `wb_valid` and `misaligned` are 0; `mem_we` is 0000; `mem_addr`, `mem_wdata`, `wb_data` and `wb_rd` are 0.
- Store latency with `mem_req_ready` tied high:
  - Cycle 0: accept.
  - Cycle 1: memory handshake.
  - Cycle 2: `req_ready` high again.
- Load latency with `mem_req_ready` high and the response one cycle after the handshake:
  - Cycle 0: accept.
  - Cycle 1: handshake.
  - Cycle 2: response.
  - Cycle 3: `wb_valid`.
- A new op may be accepted in the same cycle that `wb_valid` is high.
- Error path: accept in cycle 0, `misaligned` in cycle 1, `req_ready` high in cycle 2.
- The memory must not respond in the handshake cycle; the earliest response is the next cycle.
- Reset in any state forces IDLE on that edge.
  - An abandoned load produces no `wb_valid`.
  - Its late `mem_resp_valid` is ignored.
  - A pending `mem_req_valid` drops in the cycle after the reset edge.

## Test plan
- SB with addr `0x00001003`, wdata `0xAABBCCDD` -> `mem_addr=0x00001000`, `mem_we=1000`, `mem_wdata=0xDDDDDDDD`, no `wb_valid`.
- Response `0x12F45678` with addr `0x1002`:
  - LB -> `wb_data=0xFFFFFFF4`.
  - LBU -> `0x000000F4`.
  - LH -> `0x000012F4`.
  - `wb_rd` echoes `req_rd`, and `wb_valid` arrives exactly 3 cycles after accept.
- LW at `0x1001` and SH at `0x2003` -> one `misaligned` pulse each, `mem_req_valid` never asserted.
- Illegal load funct3=011 -> `misaligned` pulse, no memory request.
- `mem_req_ready` held low 3 cycles on SW `0x4000`/`0xCAFEBABE` -> `mem_req_valid`, `mem_addr`, `mem_we=1111` and `mem_wdata` stable throughout; `req_ready` low until the cycle after the handshake.
- LW issued, `rst` pulsed in WAIT_RESP, then `mem_resp_valid` with `0xDEADBEEF` -> no `wb_valid`; `req_ready` is 1 the cycle after reset deasserts.
- Back-to-back: LW retiring (`wb_valid`) while the next SB is accepted in the same cycle -> both complete correctly.
